// File: rtl/db_sw_pkg.sv
// Shared types and helpers for the multi-channel switch debouncer.
// Optional input synchroniser is enabled by defining DB_SW_SYNC_EN.
package db_sw_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam int unsigned TICKS_PER_SEC = 1000;

  // Clock cycles per debounce tick (1 ms).
  function automatic int unsigned tick_div(input int unsigned clk_freq);
    return clk_freq / TICKS_PER_SEC;
  endfunction

endpackage

// File: rtl/db_sw_ch.sv
// One debounce channel: optional two-flop synchroniser, stable-time FSM and edge pulses.
// Define DB_SW_SYNC_EN for inputs asynchronous to clk.
module db_sw_ch
  import db_sw_pkg::*;
#(
  parameter int unsigned DB_MS = 10
) (
  input  logic clk,
  input  logic arst_n,
  input  logic sw,
  input  logic tick,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(DB_MS);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_MS - 1);

  logic            s;
  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic            rise_q;
  logic            fall_q;

`ifdef DB_SW_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  assign sync_d = {sync_q[0], sw};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[1];
`else
  assign s = sw;
`endif

  // A revert of s takes priority over a coincident tick in the WAIT states.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ZERO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        ZERO: begin
          if (s) begin
            state_q <= WAIT1;
            cnt_q   <= '0;
          end
        end
        WAIT1: begin
          if (!s) begin
            state_q <= ZERO;
          end else if (tick) begin
            if (cnt_q == CntMax) begin
              state_q <= ONE;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ONE: begin
          if (!s) begin
            state_q <= WAIT0;
            cnt_q   <= '0;
          end
        end
        WAIT0: begin
          if (s) begin
            state_q <= ONE;
          end else if (tick) begin
            if (cnt_q == CntMax) begin
              state_q <= ZERO;
              fall_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ZERO;
      endcase
    end
  end

  assign db   = (state_q == ONE) || (state_q == WAIT0);
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/db_sw_multi.sv
// Multi-channel switch debouncer: shared 1 ms prescaler feeding N_CH independent channels.
// Define DB_SW_SYNC_EN to add a two-flop synchroniser on every input.
module db_sw_multi
  import db_sw_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 200_000_000,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DB_MS    = 10
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  localparam int unsigned TickDiv = tick_div(CLK_FREQ);
  localparam int unsigned PreW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TickDiv - 1);

  logic [PreW-1:0] pre_q;
  logic [PreW-1:0] pre_d;
  logic            tick;

  assign tick = (pre_q == PreMax);

  always_comb begin
    pre_d = pre_q + 1'b1;
    if (tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    db_sw_ch #(
      .DB_MS(DB_MS)
    ) u_ch (
      .clk   (clk),
      .arst_n(arst_n),
      .sw    (sw[i]),
      .tick  (tick),
      .db    (db[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule
